// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
//  Module   : universal_shift_register
//  Purpose  : WIDTH-bit universal shift register with hold, logical shift,
//             rotate, arithmetic shift, parallel load and synchronous clear.
//             A saturating counter reports shifts since the last load/clear
//             so serialiser/deserialiser logic can detect a completed word.
//  Revision : 1.0 - initial release
// ============================================================================
module universal_shift_register #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CW-1:0]    shift_cnt,
  output logic             word_done
);

  localparam logic [2:0] c_MODE_HOLD = 3'b000;
  localparam logic [2:0] c_MODE_SHR  = 3'b001;
  localparam logic [2:0] c_MODE_SHL  = 3'b010;
  localparam logic [2:0] c_MODE_LOAD = 3'b011;
  localparam logic [2:0] c_MODE_ROR  = 3'b100;
  localparam logic [2:0] c_MODE_ROL  = 3'b101;
  localparam logic [2:0] c_MODE_ASR  = 3'b110;
  localparam logic [2:0] c_MODE_CLR  = 3'b111;

  localparam logic [CW-1:0] c_CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_q_next;
  logic [CW-1:0]    w_cnt_next;
  logic             w_is_shift;
  logic             w_cnt_clr;

  // Next register value and counter side-effects selected by mode.
  always_comb begin
    w_q_next   = r_q;
    w_is_shift = 1'b0;
    w_cnt_clr  = 1'b0;
    case (mode)
      c_MODE_HOLD: w_q_next = r_q;
      c_MODE_SHR: begin
        w_q_next   = {sin_msb, r_q[WIDTH-1:1]};
        w_is_shift = 1'b1;
      end
      c_MODE_SHL: begin
        w_q_next   = {r_q[WIDTH-2:0], sin_lsb};
        w_is_shift = 1'b1;
      end
      c_MODE_LOAD: begin
        w_q_next  = d;
        w_cnt_clr = 1'b1;
      end
      c_MODE_ROR: begin
        w_q_next   = {r_q[0], r_q[WIDTH-1:1]};
        w_is_shift = 1'b1;
      end
      c_MODE_ROL: begin
        w_q_next   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_is_shift = 1'b1;
      end
      c_MODE_ASR: begin
        w_q_next   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_is_shift = 1'b1;
      end
      c_MODE_CLR: begin
        w_q_next  = '0;
        w_cnt_clr = 1'b1;
      end
      default: w_q_next = r_q;
    endcase
  end

  // Shift counter: cleared by load/clear, otherwise saturates at WIDTH.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_cnt_clr) begin
      w_cnt_next = '0;
    end else if (w_is_shift && (r_cnt != c_CNT_MAX)) begin
      w_cnt_next = r_cnt + CW'(1);
    end
  end

  // State registers; clock enable gates both data and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_cnt <= '0;
    end else if (en) begin
      r_q   <= w_q_next;
      r_cnt <= w_cnt_next;
    end
  end

  assign q         = r_q;
  assign sout_msb  = r_q[WIDTH-1];
  assign sout_lsb  = r_q[0];
  assign shift_cnt = r_cnt;
  assign word_done = (r_cnt == c_CNT_MAX);

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// ============================================================================
//  Module   : tb_universal_shift_register
//  Purpose  : Self-checking bench for universal_shift_register at WIDTH=8,
//             WIDTH=2 and WIDTH=64 driven by a shared stimulus stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_universal_shift_register;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic        sin_msb = 1'b0;
  logic        sin_lsb = 1'b0;
  logic [7:0]  d8 = '0;
  logic [1:0]  d2 = '0;
  logic [63:0] d64 = '0;

  logic [7:0]  q8;
  logic [1:0]  q2;
  logic [63:0] q64;
  logic [3:0]  cnt8;
  logic [1:0]  cnt2;
  logic [6:0]  cnt64;
  logic        smsb8, slsb8, wd8;
  logic        smsb2, slsb2, wd2;
  logic        smsb64, slsb64, wd64;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_on = 1'b0;

  // Reference state, one copy per width
  logic [63:0] m_q8, m_q2, m_q64;
  int          m_c8, m_c2, m_c64;

  universal_shift_register #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d8),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q8), .sout_msb(smsb8),
    .sout_lsb(slsb8), .shift_cnt(cnt8), .word_done(wd8)
  );

  universal_shift_register #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d2),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q2), .sout_msb(smsb2),
    .sout_lsb(slsb2), .shift_cnt(cnt2), .word_done(wd2)
  );

  universal_shift_register #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d64),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q64), .sout_msb(smsb64),
    .sout_lsb(slsb64), .shift_cnt(cnt64), .word_done(wd64)
  );

  always #5 clk = ~clk;

  // Arithmetic description of one register update for width w
  function automatic logic [63:0] f_next(input int w, input logic [63:0] cur,
                                         input logic [2:0] m, input logic [63:0] dv,
                                         input logic sm, input logic sl);
    logic [63:0] mask;
    logic [63:0] top;
    logic        msb;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    top  = 64'd1 << (w - 1);
    msb  = cur[w-1];
    case (m)
      3'd1:    f_next = (cur >> 1) | (sm ? top : 64'd0);
      3'd2:    f_next = ((cur << 1) | {63'd0, sl}) & mask;
      3'd3:    f_next = dv & mask;
      3'd4:    f_next = (cur >> 1) | (cur[0] ? top : 64'd0);
      3'd5:    f_next = ((cur << 1) | {63'd0, msb}) & mask;
      3'd6:    f_next = (cur >> 1) | (msb ? top : 64'd0);
      3'd7:    f_next = 64'd0;
      default: f_next = cur;
    endcase
  endfunction

  function automatic int f_cnt(input int w, input int c, input logic [2:0] m);
    if (m == 3'd3 || m == 3'd7) f_cnt = 0;
    else if (m == 3'd0)         f_cnt = c;
    else                        f_cnt = (c + 1 > w) ? w : c + 1;
  endfunction

  // Reference model update
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q8 <= '0; m_q2 <= '0; m_q64 <= '0;
      m_c8 <= 0;  m_c2 <= 0;  m_c64 <= 0;
    end else if (en) begin
      m_q8  <= f_next(8,  m_q8,  mode, {56'd0, d8}, sin_msb, sin_lsb);
      m_q2  <= f_next(2,  m_q2,  mode, {62'd0, d2}, sin_msb, sin_lsb);
      m_q64 <= f_next(64, m_q64, mode, d64,         sin_msb, sin_lsb);
      m_c8  <= f_cnt(8,  m_c8,  mode);
      m_c2  <= f_cnt(2,  m_c2,  mode);
      m_c64 <= f_cnt(64, m_c64, mode);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string name, input int w, input logic [63:0] aq,
                         input int acnt, input logic amsb, input logic alsb,
                         input logic awd, input logic [63:0] mq, input int mc);
    check({name, "_q"},    aq, mq);
    check({name, "_cnt"},  64'(acnt), 64'(mc));
    check({name, "_smsb"}, {63'd0, amsb}, {63'd0, mq[w-1]});
    check({name, "_slsb"}, {63'd0, alsb}, {63'd0, mq[0]});
    check({name, "_wd"},   {63'd0, awd}, {63'd0, (mc == w)});
    check({name, "_cnt_bound"}, {63'd0, (acnt > w)}, 64'd0);
  endtask

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    if (chk_on) begin
      cmp_dut("w8",  8,  {56'd0, q8}, int'(cnt8),  smsb8,  slsb8,  wd8,  m_q8,  m_c8);
      cmp_dut("w2",  2,  {62'd0, q2}, int'(cnt2),  smsb2,  slsb2,  wd2,  m_q2,  m_c2);
      cmp_dut("w64", 64, q64,         int'(cnt64), smsb64, slsb64, wd64, m_q64, m_c64);
    end
  end

  task automatic tick(input logic e, input logic [2:0] m, input logic [63:0] dv,
                      input logic sm, input logic sl);
    en = e; mode = m; d8 = dv[7:0]; d2 = dv[1:0]; d64 = dv;
    sin_msb = sm; sin_lsb = sl;
    @(posedge clk);
    #1;
  endtask

  // Directed literal checks on the 8-bit instance
  task automatic lit(input string name, input logic [7:0] eq, input int ec);
    check({name, "_q"},   {56'd0, q8}, {56'd0, eq});
    check({name, "_cnt"}, 64'(cnt8), 64'(ec));
  endtask

  initial begin
    logic [7:0] lsb_seq;
    #1 rst = 1'b1;
    #12 rst = 1'b0;
    check("rst_q",  {56'd0, q8}, 64'd0);
    check("rst_wd", {63'd0, wd8}, 64'd0);
    chk_on = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset mid-cycle
    tick(1, 3'd3, 64'hA5, 0, 0);
    lit("load_a5", 8'hA5, 0);
    #2 rst = 1'b1;
    #1;
    lit("async_rst", 8'h00, 0);
    check("async_rst_wd", {63'd0, wd8}, 64'd0);
    tick(1, 3'd3, 64'hFF, 0, 0);
    tick(1, 3'd3, 64'hFF, 0, 0);
    lit("rst_hold", 8'h00, 0);
    #2 rst = 1'b0;

    // Load B4 then 8+1 right shifts with sin_msb=1
    lsb_seq = 8'b1011_0100;
    tick(1, 3'd3, 64'hB4, 0, 0);
    for (int i = 0; i < 8; i++) begin
      check("shr_sout_lsb", {63'd0, slsb8}, {63'd0, lsb_seq[i]});
      tick(1, 3'd1, 64'h0, 1, 0);
    end
    lit("shr8", 8'hFF, 8);
    check("shr8_wd", {63'd0, wd8}, 64'd1);
    tick(1, 3'd1, 64'h0, 1, 0);
    lit("shr9_sat", 8'hFF, 8);
    check("shr9_wd", {63'd0, wd8}, 64'd1);

    // Rotates and arithmetic shift
    tick(1, 3'd3, 64'h81, 0, 0);
    tick(1, 3'd5, 64'h0, 0, 0);
    lit("rol", 8'h03, 1);
    tick(1, 3'd3, 64'h81, 0, 0);
    tick(1, 3'd4, 64'h0, 0, 0);
    lit("ror", 8'hC0, 1);
    tick(1, 3'd3, 64'h90, 0, 0);
    tick(1, 3'd6, 64'h0, 0, 0);
    tick(1, 3'd6, 64'h0, 0, 0);
    lit("asr2", 8'hE4, 2);

    // Enable gating
    tick(1, 3'd3, 64'h3C, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 3'd2, 64'h0, 0, 1);
    lit("en_off", 8'h3C, 0);
    tick(1, 3'd2, 64'h0, 0, 1);
    lit("en_on", 8'h79, 1);

    // Clear and load mid-word
    for (int i = 0; i < 3; i++) tick(1, 3'd2, 64'h0, 0, 1);
    tick(1, 3'd7, 64'h0, 0, 0);
    lit("clr_mid", 8'h00, 0);
    for (int i = 0; i < 3; i++) tick(1, 3'd1, 64'h0, 1, 0);
    tick(1, 3'd3, 64'h5A, 0, 0);
    lit("load_mid", 8'h5A, 0);
    tick(1, 3'd2, 64'h0, 0, 0);
    lit("load_then_shl", 8'hB4, 1);

    // WIDTH=2 boundary: shift left and rotate swap
    tick(1, 3'd3, 64'h1, 0, 0);
    check("w2_load", {62'd0, q2}, 64'd1);
    tick(1, 3'd2, 64'h0, 0, 0);
    check("w2_shl", {62'd0, q2}, 64'd2);
    tick(1, 3'd3, 64'h1, 0, 0);
    tick(1, 3'd5, 64'h0, 0, 0);
    check("w2_rot_swap", {62'd0, q2}, 64'd2);

    // Random stream with occasional asynchronous reset pulses
    for (int i = 0; i < 10000; i++) begin
      int r;
      logic [2:0] m;
      r = $urandom_range(0, 99);
      if (r < 2)      m = 3'd3;
      else if (r < 3) m = 3'd7;
      else begin
        case ($urandom_range(0, 5))
          0: m = 3'd0;
          1: m = 3'd1;
          2: m = 3'd2;
          3: m = 3'd4;
          4: m = 3'd5;
          default: m = 3'd6;
        endcase
      end
      tick(($urandom_range(0, 9) != 0), m, {$urandom, $urandom},
           $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised universal shift register: a WIDTH-bit edge-triggered register with asynchronous active-high reset, clock enable and eight operating modes (hold, logical shift, rotate, arithmetic shift, parallel load, synchronous clear). A saturating counter tracks shifts since the last load or clear, so serialiser and deserialiser logic can detect a completed word. It supersedes the single-bit storage elements in the behavioral library as the general-purpose register and serial-conversion block.

## Interface

- WIDTH, 8, register width in bits; legal range 2..64
- CW, $clog2(WIDTH+1), shift-counter width; derived, never overridden

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  clock enable; 0 = hold everything, mode ignored
- mode  input  3  operation select (see Operation)
- d  input  WIDTH  parallel load data
- sin_msb  input  1  serial input entering at bit WIDTH-1 on shift right
- sin_lsb  input  1  serial input entering at bit 0 on shift left
- q  output  WIDTH  register contents
- sout_msb  output  1  combinational q[WIDTH-1]
- sout_lsb  output  1  combinational q[0]
- shift_cnt  output  CW  shifts since last load/clear/reset, saturating at WIDTH
- word_done  output  1  combinational, 1 when shift_cnt == WIDTH

## Operation

- Reset (rst=1, asynchronous): q=0, shift_cnt=0. Derived outputs sout_msb=0, sout_lsb=0, word_done=0. Reset overrides en and mode.
- en=0: q and shift_cnt hold.
- en=1, by mode:
  - 3'b000 hold: q and shift_cnt unchanged.
  - 3'b001 shift right: q <= {sin_msb, q[WIDTH-1:1]}.
  - 3'b010 shift left: q <= {q[WIDTH-2:0], sin_lsb}.
  - 3'b011 parallel load: q <= d; shift_cnt <= 0.
  - 3'b100 rotate right: q <= {q[0], q[WIDTH-1:1]}.
  - 3'b101 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 3'b110 arithmetic shift right: q <= {q[WIDTH-1], q[WIDTH-1:1]}.
  - 3'b111 synchronous clear: q <= 0; shift_cnt <= 0.
- Shift modes are 001, 010, 100, 101 and 110. Each enabled shift-mode cycle does shift_cnt <= min(shift_cnt+1, WIDTH).
  - The counter saturates at WIDTH and never wraps.
  - Shifting continues to modify q after saturation.
- Mixing directions does not reset the counter. Only load, clear or reset do.
- No combinational path from d, mode, en or sin_* to any output. Outputs depend only on registered state.

## Timing

- Single clock domain. Every update takes effect at the rising clk edge where the controls are sampled. Latency is 1 cycle from mode/d to q.
- sout_msb, sout_lsb and word_done follow q and shift_cnt combinationally in the same cycle.
- Reset assertion clears q and shift_cnt immediately, without waiting for an edge.
- Reset deassertion: the first update happens at the first rising edge after rst falls. Deassertion must meet recovery time, which the block does not synchronise.
- Reset asserted mid-operation (for example mid-word serialisation) aborts it. The counter restarts at 0 and no partial state survives.
- Load and shift in consecutive cycles: the shift operates on the loaded value; no bubble.
- At saturation, word_done stays 1 until the next load/clear/reset.
- WIDTH=2 boundary: shift left with sin_lsb moves q[0] to q[1]. Rotate on WIDTH=2 swaps the bits.

## Test plan

- Reset, WIDTH=8: drive rst=1 mid-cycle with q=8'hA5 -> q=8'h00, shift_cnt=0, word_done=0 before the next edge. Hold rst=1 across edges with en=1, mode=011, d=8'hFF -> q stays 8'h00.
- Load then shift right, 8 cycles: load d=8'hB4, then 8 cycles of mode=001 with sin_msb=1 -> sout_lsb sequence 0,0,1,0,1,1,0,1; final q=8'hFF; shift_cnt=8 and word_done=1 after cycle 8. A 9th shift keeps shift_cnt=8.
- Rotate and arithmetic shift: load 8'h81, rotate left once -> 8'h03. Load 8'h81, rotate right once -> 8'hC0. Load 8'h90, mode=110 twice -> 8'hE4.
- Enable gating: load 8'h3C, en=0 with mode=010 for 5 cycles -> q=8'h3C, shift_cnt=0. Then en=1, mode=010, sin_lsb=1 once -> q=8'h79, shift_cnt=1.
- Clear vs load mid-word: 3 shifts then mode=111 -> q=0, shift_cnt=0. 3 shifts then load 8'h5A -> shift_cnt=0, q=8'h5A. The next cycle shift left with sin_lsb=0 -> 8'hB4, shift_cnt=1.
- Parameter sweep WIDTH=2 and WIDTH=64: a random mode/d/sin stream compared against a reference model for 10k cycles, with random async reset pulses -> zero mismatches. shift_cnt never exceeds WIDTH.
